// File: rtl/grid_game_fsm.sv
// grid_game_fsm: two-player N x N in-a-row game controller with cursor,
// one-stone-per-turn placement and a sequential line checker.
// Optional feature: define CURSOR_WRAP_EN to make cursor moves wrap around
// the board edge; the default build saturates the cursor at the edge.
//
// state   | meaning
// INIT    | idle, board held, waiting for Start
// TURN    | waiting for a button from the player to move
// RELEASE | waiting until every button is released
// CHECK   | walking the 4 lines through the last stone, one cell per cycle
// WIN     | placing player made K in a row, hold until Ack
// DRAW    | board full without a line, hold until Ack
module grid_game_fsm #(
  parameter int N = 3,
  parameter int K = 3,
  localparam int RW = $clog2(N),
  localparam int MW = $clog2(N*N+1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Ack,
  input  logic          Player1,
  input  logic [4:0]    Btn,
  input  logic [RW-1:0] RdRow,
  input  logic [RW-1:0] RdCol,
  output logic [1:0]    RdCell,
  output logic [RW-1:0] CurRow,
  output logic [RW-1:0] CurCol,
  output logic          Turn,
  output logic [MW-1:0] Moves,
  output logic [1:0]    Winner,
  output logic          Illegal,
  output logic [5:0]    State
);

  typedef enum logic [5:0] {
    S_INIT    = 6'b000001,
    S_TURN    = 6'b000010,
    S_RELEASE = 6'b000100,
    S_CHECK   = 6'b001000,
    S_WIN     = 6'b010000,
    S_DRAW    = 6'b100000
  } state_t;

  // Walker coordinates carry two extra bits so one step off either edge
  // is still representable (negative or >= N).
  localparam int PW = RW + 2;
  localparam int CW = $clog2(K + 1);
  localparam logic [RW-1:0]        LAST   = RW'(N - 1);
  localparam logic [RW-1:0]        MID    = RW'(N / 2);
  localparam logic [MW-1:0]        CELLS  = MW'(N * N);
  localparam logic [CW-1:0]        KC     = CW'(K);
  localparam logic [CW-1:0]        RUN1   = CW'(1);
  localparam logic signed [PW-1:0] LAST_S = PW'(N - 1);
  localparam logic signed [PW-1:0] ONE    = PW'(1);

  logic [1:0] rst_sync;
  logic       rst_n;

  state_t          state_q, state_d;
  logic [RW-1:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [RW-1:0]   last_row_q, last_row_d, last_col_q, last_col_d;
  logic            turn_q, turn_d;
  logic [MW-1:0]   moves_q, moves_d;
  logic [1:0]      winner_q, winner_d;
  logic            illegal_q, illegal_d;
  logic [1:0]      dir_q, dir_d;
  logic            side_q, side_d;
  logic [CW-1:0]   run_q, run_d, run_inc;
  logic signed [PW-1:0] wr_q, wr_d, wc_q, wc_d;
  logic signed [PW-1:0] dr, dc, nr, nc, home_r, home_c;
  logic [1:0]      board [N][N];
  logic [1:0]      own, cur_cell, cell_n;
  logic            in_board, hit, win_now;
  logic            board_clr, board_we;

  function automatic logic [RW-1:0] step_inc(input logic [RW-1:0] p);
`ifdef CURSOR_WRAP_EN
    step_inc = (p == LAST) ? '0 : p + 1'b1;
`else
    step_inc = (p == LAST) ? p : p + 1'b1;
`endif
  endfunction

  function automatic logic [RW-1:0] step_dec(input logic [RW-1:0] p);
`ifdef CURSOR_WRAP_EN
    step_dec = (p == '0) ? LAST : p - 1'b1;
`else
    step_dec = (p == '0) ? p : p - 1'b1;
`endif
  endfunction

  // Reset asserts asynchronously, releases two Clk edges after Reset rises.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign own      = turn_q ? 2'b10 : 2'b01;
  assign cur_cell = board[cur_row_q][cur_col_q];
  assign home_r   = $signed({2'b00, last_row_q});
  assign home_c   = $signed({2'b00, last_col_q});
  assign run_inc  = run_q + 1'b1;

  // Next cell on the current line: dir 0 row, 1 column, 2 diagonal, 3 anti-diagonal;
  // side 1 walks the opposite way.
  always_comb begin
    dr = '0;
    dc = '0;
    case (dir_q)
      2'd0: begin dr = '0;  dc = ONE;  end
      2'd1: begin dr = ONE; dc = '0;   end
      2'd2: begin dr = ONE; dc = ONE;  end
      2'd3: begin dr = ONE; dc = -ONE; end
    endcase
    if (side_q) begin
      dr = -dr;
      dc = -dc;
    end
    nr       = wr_q + dr;
    nc       = wc_q + dc;
    in_board = !nr[PW-1] && !nc[PW-1] && (nr <= LAST_S) && (nc <= LAST_S);
    cell_n   = 2'b00;
    if (in_board) cell_n = board[nr[RW-1:0]][nc[RW-1:0]];
    hit      = in_board && (cell_n == own);
    win_now  = hit && (run_inc >= KC);
  end

  // Next-state and register updates for the game sequence.
  always_comb begin
    state_d    = state_q;
    cur_row_d  = cur_row_q;
    cur_col_d  = cur_col_q;
    last_row_d = last_row_q;
    last_col_d = last_col_q;
    turn_d     = turn_q;
    moves_d    = moves_q;
    winner_d   = winner_q;
    illegal_d  = 1'b0;
    dir_d      = dir_q;
    side_d     = side_q;
    run_d      = run_q;
    wr_d       = wr_q;
    wc_d       = wc_q;
    board_clr  = 1'b0;
    board_we   = 1'b0;
    case (state_q)
      S_INIT: begin
        if (Start) begin
          board_clr = 1'b1;
          moves_d   = '0;
          winner_d  = 2'b00;
          cur_row_d = MID;
          cur_col_d = MID;
          turn_d    = ~Player1;
          state_d   = S_TURN;
        end
      end
      S_TURN: begin
        if (Btn[4]) begin
          if (cur_cell == 2'b00) begin
            board_we   = 1'b1;
            moves_d    = moves_q + 1'b1;
            last_row_d = cur_row_q;
            last_col_d = cur_col_q;
            dir_d      = 2'd0;
            side_d     = 1'b0;
            run_d      = RUN1;
            wr_d       = $signed({2'b00, cur_row_q});
            wc_d       = $signed({2'b00, cur_col_q});
            state_d    = S_CHECK;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_RELEASE;
          end
        end else if (Btn[0]) begin
          cur_col_d = step_inc(cur_col_q);
          state_d   = S_RELEASE;
        end else if (Btn[1]) begin
          cur_col_d = step_dec(cur_col_q);
          state_d   = S_RELEASE;
        end else if (Btn[3]) begin
          cur_row_d = step_dec(cur_row_q);
          state_d   = S_RELEASE;
        end else if (Btn[2]) begin
          cur_row_d = step_inc(cur_row_q);
          state_d   = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (Btn == 5'b00000) state_d = S_TURN;
      end
      S_CHECK: begin
        if (win_now) begin
          winner_d = own;
          state_d  = S_WIN;
        end else if (hit) begin
          run_d = run_inc;
          wr_d  = nr;
          wc_d  = nc;
        end else if (!side_q) begin
          side_d = 1'b1;
          wr_d   = home_r;
          wc_d   = home_c;
        end else if (dir_q != 2'd3) begin
          dir_d  = dir_q + 1'b1;
          side_d = 1'b0;
          run_d  = RUN1;
          wr_d   = home_r;
          wc_d   = home_c;
        end else if (moves_q == CELLS) begin
          state_d = S_DRAW;
        end else begin
          turn_d  = ~turn_q;
          state_d = S_RELEASE;
        end
      end
      S_WIN, S_DRAW: begin
        if (Ack) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and control registers.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      cur_row_q  <= MID;
      cur_col_q  <= MID;
      last_row_q <= '0;
      last_col_q <= '0;
      turn_q     <= 1'b0;
      moves_q    <= '0;
      winner_q   <= 2'b00;
      illegal_q  <= 1'b0;
      dir_q      <= 2'd0;
      side_q     <= 1'b0;
      run_q      <= '0;
      wr_q       <= '0;
      wc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cur_row_q  <= cur_row_d;
      cur_col_q  <= cur_col_d;
      last_row_q <= last_row_d;
      last_col_q <= last_col_d;
      turn_q     <= turn_d;
      moves_q    <= moves_d;
      winner_q   <= winner_d;
      illegal_q  <= illegal_d;
      dir_q      <= dir_d;
      side_q     <= side_d;
      run_q      <= run_d;
      wr_q       <= wr_d;
      wc_q       <= wc_d;
    end
  end

  // Board storage: cleared on reset and game start, one write per placement.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          board[r][c] <= 2'b00;
    end else if (board_clr) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          board[r][c] <= 2'b00;
    end else if (board_we) begin
      board[cur_row_q][cur_col_q] <= own;
    end
  end

  // Combinational board read port; coordinates past the board read empty.
  always_comb begin
    RdCell = 2'b00;
    if ((RdRow <= LAST) && (RdCol <= LAST)) RdCell = board[RdRow][RdCol];
  end

  assign CurRow  = cur_row_q;
  assign CurCol  = cur_col_q;
  assign Turn    = turn_q;
  assign Moves   = moves_q;
  assign Winner  = winner_q;
  assign Illegal = illegal_q;
  assign State   = state_q;

endmodule

// File: tb/tb_grid_game_fsm.sv
// tb_grid_game_fsm: directed bench for grid_game_fsm, one 3x3/K=3 instance
// and one 5x5/K=4 instance sharing stimulus through a select.
module tb_grid_game_fsm;

  localparam logic [31:0] ST_INIT = 32'd1,  ST_TURN = 32'd2,  ST_REL = 32'd4;
  localparam logic [31:0] ST_CHECK = 32'd8, ST_WIN = 32'd16, ST_DRAW = 32'd32;
  localparam logic [4:0]  B_P = 5'b10000, B_U = 5'b01000, B_D = 5'b00100;
  localparam logic [4:0]  B_L = 5'b00010, B_R = 5'b00001;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset, start, ack, p1, sel;
  logic [4:0] btn;
  logic [2:0] rd_row, rd_col;

  logic [1:0] rd_cell3, cur_row3, cur_col3, winner3;
  logic [3:0] moves3;
  logic       turn3, illegal3;
  logic [5:0] state3;
  logic [1:0] rd_cell5, winner5;
  logic [2:0] cur_row5, cur_col5;
  logic [4:0] moves5;
  logic       turn5, illegal5;
  logic [5:0] state5;

  grid_game_fsm #(.N(3), .K(3)) u_dut3 (
    .Clk(Clk), .Reset(Reset), .Start(start & ~sel), .Ack(ack & ~sel), .Player1(p1),
    .Btn(sel ? 5'b0 : btn), .RdRow(rd_row[1:0]), .RdCol(rd_col[1:0]), .RdCell(rd_cell3),
    .CurRow(cur_row3), .CurCol(cur_col3), .Turn(turn3), .Moves(moves3),
    .Winner(winner3), .Illegal(illegal3), .State(state3)
  );

  grid_game_fsm #(.N(5), .K(4)) u_dut5 (
    .Clk(Clk), .Reset(Reset), .Start(start & sel), .Ack(ack & sel), .Player1(p1),
    .Btn(sel ? btn : 5'b0), .RdRow(rd_row), .RdCol(rd_col), .RdCell(rd_cell5),
    .CurRow(cur_row5), .CurCol(cur_col5), .Turn(turn5), .Moves(moves5),
    .Winner(winner5), .Illegal(illegal5), .State(state5)
  );

  logic [31:0] o_state, o_row, o_col, o_turn, o_moves, o_win, o_ill, o_cell;
  assign o_state = sel ? 32'(state5)    : 32'(state3);
  assign o_row   = sel ? 32'(cur_row5)  : 32'(cur_row3);
  assign o_col   = sel ? 32'(cur_col5)  : 32'(cur_col3);
  assign o_turn  = sel ? 32'(turn5)     : 32'(turn3);
  assign o_moves = sel ? 32'(moves5)    : 32'(moves3);
  assign o_win   = sel ? 32'(winner5)   : 32'(winner3);
  assign o_ill   = sel ? 32'(illegal5)  : 32'(illegal3);
  assign o_cell  = sel ? 32'(rd_cell5)  : 32'(rd_cell3);

  int n_cmp, n_err;
  int cr, cc, last_cyc;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic press(input logic [4:0] b);
    btn = b;
    tick();
    btn = 5'b0;
    tick();
  endtask

  task automatic goto(input int r, input int c);
    while (cc < c) begin press(B_R); cc++; end
    while (cc > c) begin press(B_L); cc--; end
    while (cr < r) begin press(B_D); cr++; end
    while (cr > r) begin press(B_U); cr--; end
  endtask

  task automatic place_at(input int r, input int c);
    logic done;
    goto(r, c);
    btn = B_P;
    tick();
    btn = 5'b0;
    last_cyc = 1;
    done = 1'b0;
    while (!done && last_cyc < 60) begin
      done = (o_state == ST_TURN) || (o_state == ST_WIN) || (o_state == ST_DRAW);
      if (!done) begin tick(); last_cyc++; end
    end
    check_val("place_settles", 32'(done), 32'd1);
  endtask

  task automatic cell_is(input string tag, input int r, input int c, input logic [31:0] exp);
    rd_row = 3'(r);
    rd_col = 3'(c);
    #1;
    check_val(tag, o_cell, exp);
  endtask

  task automatic new_game(input logic who);
    p1 = who;
    start = 1'b1;
    tick();
    start = 1'b0;
    cr = sel ? 2 : 1;
    cc = cr;
  endtask

  initial begin
    int nz;
    int exp_col;
    n_cmp = 0; n_err = 0;
    Reset = 1'b0; start = 1'b0; ack = 1'b0; p1 = 1'b0; sel = 1'b0;
    btn = 5'b0; rd_row = '0; rd_col = '0;
    repeat (3) tick();

    // reset values
    check_val("rst_state", o_state, ST_INIT);
    check_val("rst_moves", o_moves, 0);
    check_val("rst_winner", o_win, 0);
    check_val("rst_turn", o_turn, 0);
    check_val("rst_illegal", o_ill, 0);
    check_val("rst_cur_row", o_row, 1);
    check_val("rst_cur_col", o_col, 1);
    Reset = 1'b1;
    repeat (4) tick();
    check_val("idle_without_start", o_state, ST_INIT);

    // game 1: P1 wins on row 0
    new_game(1'b1);
    check_val("g1_state", o_state, ST_TURN);
    check_val("g1_turn_p1", o_turn, 0);
    place_at(0, 0);
    check_val("g1_turn_toggled", o_turn, 1);
    check_val("g1_moves1", o_moves, 1);
    cell_is("g1_cell00", 0, 0, 1);
    place_at(1, 0);
    place_at(0, 1);
    place_at(1, 1);
    place_at(0, 2);
    check_val("g1_win_state", o_state, ST_WIN);
    check_val("g1_winner", o_win, 1);
    check_val("g1_moves5", o_moves, 5);
    check_val("g1_turn_kept", o_turn, 0);
    cell_is("g1_cell11", 1, 1, 2);
    cell_is("g1_cell_oob", 3, 0, 0);
    start = 1'b1; btn = B_P;
    tick();
    start = 1'b0; btn = 5'b0;
    check_val("g1_start_ignored", o_state, ST_WIN);
    check_val("g1_btn_ignored", o_moves, 5);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("g1_ack_to_init", o_state, ST_INIT);

    // game 2: P2 first, illegal placement, cursor behaviour, reset mid-check
    new_game(1'b0);
    check_val("g2_turn_p2", o_turn, 1);
    cell_is("g2_board_cleared", 0, 0, 0);
    place_at(1, 1);
    check_val("g2_turn_p1", o_turn, 0);
    cell_is("g2_cell11", 1, 1, 2);
    btn = B_P;
    tick();
    check_val("g2_illegal_high", o_ill, 1);
    check_val("g2_illegal_release", o_state, ST_REL);
    btn = 5'b0;
    tick();
    check_val("g2_illegal_low", o_ill, 0);
    check_val("g2_illegal_turn", o_turn, 0);
    check_val("g2_illegal_moves", o_moves, 1);
    press(B_R | B_L);
    cc = 2;
    check_val("g2_prio_right", o_col, 2);
    btn = B_R;
    repeat (10) tick();
    btn = 5'b0;
    tick();
`ifdef CURSOR_WRAP_EN
    exp_col = 0;
`else
    exp_col = 2;
`endif
    cc = exp_col;
    check_val("g2_hold_right_col", o_col, 32'(exp_col));
    check_val("g2_hold_right_row", o_row, 1);
    check_val("g2_hold_back_turn", o_state, ST_TURN);
    press(B_U | B_D);
    cr = 0;
    check_val("g2_prio_up", o_row, 0);
    btn = B_P;
    tick();
    btn = 5'b0;
    check_val("g2_in_check", o_state, ST_CHECK);
    Reset = 1'b0;
    #1;
    check_val("g2_rst_state", o_state, ST_INIT);
    check_val("g2_rst_moves", o_moves, 0);
    check_val("g2_rst_cursor", o_row * 4 + o_col, 5);
    nz = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        if (o_cell != 0) nz++;
      end
    check_val("g2_rst_board_empty", 32'(nz), 0);
    tick();
    Reset = 1'b1;
    repeat (3) tick();
    check_val("g2_after_rst_idle", o_state, ST_INIT);

    // game 3: draw X O X / X O O / O X X, X = P1 moving first
    new_game(1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("g3_ack_ignored", o_state, ST_TURN);
    place_at(0, 0);
    place_at(0, 1);
    place_at(0, 2);
    place_at(1, 1);
    place_at(1, 0);
    place_at(1, 2);
    place_at(2, 1);
    place_at(2, 0);
    place_at(2, 2);
    check_val("g3_draw_state", o_state, ST_DRAW);
    check_val("g3_draw_winner", o_win, 0);
    check_val("g3_draw_moves", o_moves, 9);
    cell_is("g3_cell20", 2, 0, 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("g3_ack_to_init", o_state, ST_INIT);

    // game 4: 5x5, K=4, P2 completes anti-diagonal
    sel = 1'b1;
    #1;
    new_game(1'b0);
    check_val("g4_turn_p2", o_turn, 1);
    check_val("g4_cursor_mid", o_row * 8 + o_col, 18);
    place_at(0, 3);
    place_at(4, 4);
    place_at(1, 2);
    place_at(4, 3);
    place_at(2, 1);
    place_at(4, 0);
    check_val("g4_no_early_win", o_state, ST_TURN);
    place_at(3, 0);
    check_val("g4_win_state", o_state, ST_WIN);
    check_val("g4_winner", o_win, 2);
    check_val("g4_moves", o_moves, 7);
    check_val("g4_latency_ok", 32'(last_cyc <= 25), 1);
    cell_is("g4_cell30", 3, 0, 2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_val("g4_ack_to_init", o_state, ST_INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/grid_game_fsm.md
GRID_GAME_FSM -- requirements
Module: grid_game_fsm

Interface
REQ-001 SHALL have parameter N, default 3, meaning board side length; legal range 3..8.
REQ-002 SHALL have parameter K, default 3, meaning in-a-row length needed to win; legal range 3..N.
REQ-003 SHALL have port Clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to Clk).
REQ-005 SHALL have port Start  input  1  begin a new game from INIT.
REQ-006 SHALL have port Ack  input  1  acknowledge result in WIN/DRAW.
REQ-007 SHALL have port Player1  input  1  first mover select, 1 = player 1, 0 = player 2; sampled on Start.
REQ-008 SHALL have port Btn  input  5  {Place, Up, Down, Left, Right}, level-sensitive, externally debounced.
REQ-009 SHALL have port RdRow  input  RW  board read row, RW = clog2(N).
REQ-010 SHALL have port RdCol  input  RW  board read column.
REQ-011 SHALL have port RdCell  output  2  combinational cell at (RdRow,RdCol): 00 empty, 01 P1, 10 P2; out-of-range reads 00.
REQ-012 SHALL have port CurRow  output  RW  cursor row.
REQ-013 SHALL have port CurCol  output  RW  cursor column.
REQ-014 SHALL have port Turn  output  1  player to move, 0 = P1, 1 = P2.
REQ-015 SHALL have port Moves  output  MW  stones placed this game, MW = clog2(N*N+1).
REQ-016 SHALL have port Winner  output  2  00 none, 01 P1, 10 P2; valid in WIN.
REQ-017 SHALL have port Illegal  output  1  one-cycle pulse on Place onto occupied cell.
REQ-018 SHALL have port State  output  6  one-hot {DRAW, WIN, CHECK, RELEASE, TURN, INIT}.

Function
REQ-019 SHALL implement states INIT, TURN, RELEASE, CHECK, WIN, DRAW, exactly one State bit high.
REQ-020 INIT: on Start SHALL clear board, Moves=0, Winner=00, cursor=(N/2,N/2), Turn=~Player1, then go TURN.
REQ-021 TURN: no button -> stay; multiple buttons -> priority Place > Right > Left > Up > Down, one action per press.
REQ-022 TURN move button SHALL step cursor one cell in that direction and go RELEASE, board unchanged.
REQ-023 TURN Place on empty cell SHALL write Turn's code to cursor cell, Moves+1, go CHECK next cycle.
REQ-024 TURN Place on occupied cell SHALL pulse Illegal for one cycle, leave board/Moves/Turn unchanged, go RELEASE.
REQ-025 RELEASE SHALL go TURN in the first cycle all five Btn bits are 0; held buttons never repeat.
REQ-026 CHECK SHALL examine one cell per cycle through the last placed cell in 4 directions (row, column, diagonal, anti-diagonal), each side walked until off-board, non-own cell, or K-1 cells counted.
REQ-027 CHECK SHALL complete in at most 8*(K-1)+1 cycles and go WIN as soon as any direction's run (own cells both sides + 1) reaches K.
REQ-028 On WIN SHALL set Winner to the placing player's code; Turn unchanged.
REQ-029 CHECK with no win and Moves == N*N SHALL go DRAW (Winner=00); win on the final cell SHALL take precedence over draw.
REQ-030 CHECK with no win and Moves < N*N SHALL toggle Turn and go RELEASE.
REQ-031 WIN/DRAW SHALL hold board and outputs until Ack, then go INIT; Start is ignored outside INIT, Ack outside WIN/DRAW.
REQ-032 Buttons SHALL be ignored in INIT, CHECK, WIN, DRAW.

Reset
REQ-033 Reset low SHALL immediately force INIT, empty board, Moves=0, Winner=00, Turn=0, Illegal=0, cursor=(N/2,N/2), including mid-CHECK.
REQ-034 After Reset high, first transition SHALL occur no earlier than the first Clk edge with Start high.

Configuration
REQ-035 With CURSOR_WRAP_EN defined, cursor past an edge SHALL wrap within its row/column (e.g. Right at col N-1 -> col 0).
REQ-036 Without CURSOR_WRAP_EN, cursor past an edge SHALL saturate at the edge (position unchanged), still going RELEASE.

Verification
REQ-037 N=3,K=3, Player1=1: P1 places (0,0),(0,1),(0,2), P2 (1,0),(1,1) -> WIN, Winner=01, Moves=5.
REQ-038 N=3: fill board with no line (X O X / X O O / O X X) -> DRAW, Winner=00, Moves=9; Ack -> INIT.
REQ-039 Place on occupied cell -> Illegal high exactly 1 cycle, Turn and Moves unchanged.
REQ-040 Cursor at (1,2), Right held 10 cycles -> cursor (1,0) with wrap or (1,2) without, moved once only.
REQ-041 N=5,K=4: P2 completes anti-diagonal (0,3),(1,2),(2,1),(3,0) -> WIN, Winner=10 within 25 cycles of Place.
REQ-042 Reset low during CHECK -> State=INIT and RdCell=00 for all cells before next Clk edge.
